// File: rtl/sram_tdp_be.sv
// sram_tdp_be: single-clock true dual-port SRAM with per-port byte enables,
// selectable read latency (1 or 2), per-port read-during-write mode, a
// defined same-address collision policy and an optional post-reset clear sweep.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   cs                    chip select, gates both ports
//   we_X, re_X            port X write / read enable            (X = A, B)
//   be_X                  port X byte enables (bit i -> lane i)
//   add_X                 port X address
//   data_inX / data_outX  port X write data / registered read data
//   valid_X               one-cycle pulse per completed read on port X
//   collision             pulse: both ports wrote one address with overlapping lanes
//   busy                  clear sweep in progress; port requests ignored
module sram_tdp_be #(
    parameter int unsigned depth          = 16,
    parameter int unsigned width          = 32,
    parameter int unsigned READ_LAT       = 1,
    parameter int unsigned WRITE_FIRST    = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cs,
    input  logic                     we_A,
    input  logic                     re_A,
    input  logic [width/8-1:0]       be_A,
    input  logic [$clog2(depth)-1:0] add_A,
    input  logic [width-1:0]         data_inA,
    output logic [width-1:0]         data_outA,
    output logic                     valid_A,
    input  logic                     we_B,
    input  logic                     re_B,
    input  logic [width/8-1:0]       be_B,
    input  logic [$clog2(depth)-1:0] add_B,
    input  logic [width-1:0]         data_inB,
    output logic [width-1:0]         data_outB,
    output logic                     valid_B,
    output logic                     collision,
    output logic                     busy
);

    localparam int unsigned AW = $clog2(depth);
    localparam int unsigned NB = width / 8;

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    logic [width-1:0] r_mem [depth];

    state_t          r_state, w_state_nxt;
    logic [AW-1:0]   r_ptr, w_ptr_nxt;
    logic            r_busy, w_busy_nxt;
    logic            w_clr_we;

    logic            r_s1_vA, r_s1_vB;
    logic [width-1:0] r_s1_dA, r_s1_dB;
    logic            r_vA, r_vB, r_coll;
    logic [width-1:0] r_doutA, r_doutB;

    logic            w_acc, w_inr_A, w_inr_B, w_wr_A, w_wr_B, w_rd_A, w_rd_B;
    logic [width-1:0] w_old_A, w_old_B, w_base_A, w_wdata_A, w_wdata_B;
    logic [width-1:0] w_rdata_A, w_rdata_B;

    // Replace lanes of old_w with new_w wherever be is set.
    function automatic logic [width-1:0] f_merge(input logic [width-1:0] old_w,
                                                 input logic [width-1:0] new_w,
                                                 input logic [NB-1:0]    be);
        logic [width-1:0] res;
        res = old_w;
        for (int i = 0; i < int'(NB); i++) begin
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

    // Request qualification; out-of-range writes are dropped, reads return 0.
    assign w_acc   = cs && !r_busy;
    assign w_inr_A = 32'(add_A) < depth;
    assign w_inr_B = 32'(add_B) < depth;
    assign w_wr_A  = w_acc && we_A && w_inr_A;
    assign w_wr_B  = w_acc && we_B && w_inr_B;
    assign w_rd_A  = w_acc && re_A;
    assign w_rd_B  = w_acc && re_B;

    // Write/read data paths. On a same-address double write, port A's word is
    // built on top of port B's lanes so A wins only where both are enabled.
    always_comb begin
        w_old_A   = w_inr_A ? r_mem[add_A] : '0;
        w_old_B   = w_inr_B ? r_mem[add_B] : '0;
        w_base_A  = (w_wr_B && (add_B == add_A)) ? f_merge(w_old_A, data_inB, be_B) : w_old_A;
        w_wdata_A = f_merge(w_base_A, data_inA, be_A);
        w_wdata_B = f_merge(w_old_B, data_inB, be_B);
        w_rdata_A = ((WRITE_FIRST != 0) && we_A && w_inr_A) ? f_merge(w_old_A, data_inA, be_A) : w_old_A;
        w_rdata_B = ((WRITE_FIRST != 0) && we_B && w_inr_B) ? f_merge(w_old_B, data_inB, be_B) : w_old_B;
    end

    // Array: untouched while rst is high; the clear sweep owns it while busy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_clr_we) begin
                r_mem[r_ptr] <= '0;
            end else begin
                if (w_wr_B) r_mem[add_B] <= w_wdata_B;
                if (w_wr_A) r_mem[add_A] <= w_wdata_A;
            end
        end
    end

    // Clear FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
            r_ptr   <= '0;
            r_busy  <= (CLEAR_ON_RESET != 0);
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Clear FSM next state: one word zeroed per cycle, busy drops on entering IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_busy_nxt  = 1'b0;
        w_clr_we    = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_clr_we = 1'b1;
                if (32'(r_ptr) == depth - 1) begin
                    w_state_nxt = S_IDLE;
                    w_ptr_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_ptr_nxt  = r_ptr + AW'(1);
                    w_busy_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Read pipeline and collision flag; data_out holds when no read completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vA <= 1'b0;
            r_s1_vB <= 1'b0;
            r_s1_dA <= '0;
            r_s1_dB <= '0;
            r_vA    <= 1'b0;
            r_vB    <= 1'b0;
            r_doutA <= '0;
            r_doutB <= '0;
            r_coll  <= 1'b0;
        end else begin
            r_s1_vA <= w_rd_A;
            r_s1_vB <= w_rd_B;
            r_s1_dA <= w_rdata_A;
            r_s1_dB <= w_rdata_B;
            if (READ_LAT == 2) begin
                r_vA <= r_s1_vA;
                r_vB <= r_s1_vB;
                if (r_s1_vA) r_doutA <= r_s1_dA;
                if (r_s1_vB) r_doutB <= r_s1_dB;
            end else begin
                r_vA <= w_rd_A;
                r_vB <= w_rd_B;
                if (w_rd_A) r_doutA <= w_rdata_A;
                if (w_rd_B) r_doutB <= w_rdata_B;
            end
            r_coll <= w_wr_A && w_wr_B && (add_A == add_B) && ((be_A & be_B) != '0);
        end
    end

    assign data_outA = r_doutA;
    assign data_outB = r_doutB;
    assign valid_A   = r_vA;
    assign valid_B   = r_vB;
    assign collision = r_coll;
    assign busy      = r_busy;

endmodule
